// File: rtl/l2_flush_ctrl.sv
// l2_flush_ctrl -- L2 flush sequencer.
//
// Walks every set/way of the L2 after a flush_start pulse. For each line the
// tag/state is read, dirty lines are written back, and every valid line is
// invalidated. The set/way pointers live in the downstream register block;
// this block only pulses increment/clear controls and reads the pointers back.
//
// Optional build macro: L2_FLUSH_WB_CNT_EN adds a 16-bit saturating counter
// of accepted writebacks (wb_count), cleared when a flush is accepted.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   flush_start          one-cycle flush request (ignored while busy)
//   flush_set/flush_way  current pointers from the register block (MSB ignored)
//   reqs_cnt             free request slots; writeback only offered when != 0
//   set/clr_ongoing_flush, incr/clr_flush_set, incr/clr_flush_way,
//   fill_reqs_flush      one-cycle control pulses toward the register block
//   tag_rd_en            tag read strobe; tag_valid/tag_dirty return next cycle
//   inval_en             invalidate line (flush_set, flush_way)
//   wb_valid/wb_ready    writeback request handshake
//   flush_busy           high while a walk is in progress
//   flush_done           one-cycle completion pulse
//   wb_count             (optional) accepted writeback count
module l2_flush_ctrl #(
    parameter int L2_SETS      = 256,
    parameter int L2_WAYS      = 8,
    parameter int REQS_BITS_P1 = 3,
    localparam int SET_BITS    = $clog2(L2_SETS),
    localparam int WAY_BITS    = $clog2(L2_WAYS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_start,
    input  logic [SET_BITS:0]       flush_set,
    input  logic [WAY_BITS:0]       flush_way,
    input  logic [REQS_BITS_P1-1:0] reqs_cnt,
    output logic                    set_ongoing_flush,
    output logic                    clr_ongoing_flush,
    output logic                    incr_flush_set,
    output logic                    clr_flush_set,
    output logic                    incr_flush_way,
    output logic                    clr_flush_way,
    output logic                    fill_reqs_flush,
    output logic                    tag_rd_en,
    input  logic                    tag_valid,
    input  logic                    tag_dirty,
    output logic                    inval_en,
    output logic                    wb_valid,
    input  logic                    wb_ready,
`ifdef L2_FLUSH_WB_CNT_EN
    output logic [15:0]             wb_count,
`endif
    output logic                    flush_busy,
    output logic                    flush_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_WB,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t state, state_nx;

    // Keeps wb_valid asserted once offered, even if reqs_cnt falls to zero
    // before the request is accepted.
    logic wb_hold, wb_hold_nx;

    logic way_last, set_last, accept, xfer;

    // Pointer MSBs are not part of the index.
    logic unused_msbs;
    assign unused_msbs = ^{flush_set[SET_BITS], flush_way[WAY_BITS]};

    assign way_last = (flush_way[WAY_BITS-1:0] == WAY_BITS'(L2_WAYS - 1));
    assign set_last = (flush_set[SET_BITS-1:0] == SET_BITS'(L2_SETS - 1));

    // A start seen while reset is asserted must not disturb the register block.
    assign accept = (state == S_IDLE) && flush_start && rst;
    assign xfer   = wb_valid && wb_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            wb_hold <= 1'b0;
        end else begin
            state   <= state_nx;
            wb_hold <= wb_hold_nx;
        end
    end

    always_comb begin
        state_nx          = state;
        wb_hold_nx        = 1'b0;
        set_ongoing_flush = 1'b0;
        clr_ongoing_flush = 1'b0;
        incr_flush_set    = 1'b0;
        clr_flush_set     = 1'b0;
        incr_flush_way    = 1'b0;
        clr_flush_way     = 1'b0;
        fill_reqs_flush   = 1'b0;
        tag_rd_en         = 1'b0;
        inval_en          = 1'b0;
        wb_valid          = 1'b0;
        flush_done        = 1'b0;
        flush_busy        = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (accept) begin
                    set_ongoing_flush = 1'b1;
                    clr_flush_set     = 1'b1;
                    clr_flush_way     = 1'b1;
                    state_nx          = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                tag_rd_en = 1'b1;
                state_nx  = S_CHECK;
            end
            S_CHECK: begin
                if (tag_valid && tag_dirty) begin
                    state_nx = S_WB;
                end else begin
                    inval_en = tag_valid;
                    state_nx = S_ADVANCE;
                end
            end
            S_WB: begin
                wb_valid = (reqs_cnt != '0) || wb_hold;
                if (xfer) begin
                    fill_reqs_flush = 1'b1;
                    inval_en        = 1'b1;
                    state_nx        = S_ADVANCE;
                end else begin
                    wb_hold_nx = wb_valid;
                end
            end
            S_ADVANCE: begin
                if (!way_last) begin
                    incr_flush_way = 1'b1;
                    state_nx       = S_LOOKUP;
                end else if (!set_last) begin
                    clr_flush_way  = 1'b1;
                    incr_flush_set = 1'b1;
                    state_nx       = S_LOOKUP;
                end else begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                clr_ongoing_flush = 1'b1;
                clr_flush_set     = 1'b1;
                clr_flush_way     = 1'b1;
                flush_done        = 1'b1;
                state_nx          = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef L2_FLUSH_WB_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_count <= '0;
        end else if (accept) begin
            wb_count <= '0;
        end else if (xfer && (wb_count != 16'hFFFF)) begin
            wb_count <= wb_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_flush_ctrl.sv
// Self-checking bench for l2_flush_ctrl with a 4-set x 2-way cache.
// Surrounds the DUT with a register-block model (pointers, ongoing flag) and
// a tag-array model, logs observed events, and compares them with tables and
// a line-by-line reference of which lines get written back / invalidated.
module tb_l2_flush_ctrl;
    localparam int SETS  = 4;
    localparam int WAYS  = 2;
    localparam int LINES = SETS * WAYS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush_start = 1'b0;
    logic [2:0] fset = '0;
    logic [1:0] fway = '0;
    logic [2:0] reqs_cnt = 3'd2;
    logic       wb_ready = 1'b1;
    logic       tag_valid = 1'b0, tag_dirty = 1'b0;
    logic       ongoing = 1'b0;
    logic [7:0] tv = '0, td = '0;

    logic set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set;
    logic incr_flush_way, clr_flush_way, fill_reqs_flush, tag_rd_en, inval_en;
    logic wb_valid, flush_busy, flush_done;
`ifdef L2_FLUSH_WB_CNT_EN
    logic [15:0] wb_count;
`endif

    always #5 clk = ~clk;

    l2_flush_ctrl #(.L2_SETS(SETS), .L2_WAYS(WAYS), .REQS_BITS_P1(3)) dut (
        .clk(clk), .rst(rst), .flush_start(flush_start),
        .flush_set(fset), .flush_way(fway), .reqs_cnt(reqs_cnt),
        .set_ongoing_flush(set_ongoing_flush), .clr_ongoing_flush(clr_ongoing_flush),
        .incr_flush_set(incr_flush_set), .clr_flush_set(clr_flush_set),
        .incr_flush_way(incr_flush_way), .clr_flush_way(clr_flush_way),
        .fill_reqs_flush(fill_reqs_flush), .tag_rd_en(tag_rd_en),
        .tag_valid(tag_valid), .tag_dirty(tag_dirty), .inval_en(inval_en),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
`ifdef L2_FLUSH_WB_CNT_EN
        .wb_count(wb_count),
`endif
        .flush_busy(flush_busy), .flush_done(flush_done)
    );

    function automatic int cur_line();
        return int'(fset[1:0]) * WAYS + int'(fway[0]);
    endfunction

    function automatic logic [11:0] outs();
        return {set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set,
                incr_flush_way, clr_flush_way, fill_reqs_flush, tag_rd_en,
                inval_en, wb_valid, flush_busy, flush_done};
    endfunction

    // register block + tag array models
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr_flush_set) fset <= '0; else if (incr_flush_set) fset <= fset + 3'd1;
        if (clr_flush_way) fway <= '0; else if (incr_flush_way) fway <= fway + 2'd1;
        if (set_ongoing_flush) ongoing <= 1'b1; else if (clr_ongoing_flush) ongoing <= 1'b0;
        if (tag_rd_en) begin
            tag_valid <= tv[cur_line()];
            tag_dirty <= td[cur_line()];
        end
    end

    // event log, sampled mid-cycle
    int rd_q[$], inv_q[$], wb_q[$], done_q[$];
    int n_fill = 0, n_bad = 0;
    always @(negedge clk) begin
        if (tag_rd_en) rd_q.push_back(cur_line());
        if (inval_en) inv_q.push_back(cur_line());
        if (wb_valid && wb_ready) wb_q.push_back(cur_line());
        if (flush_done) done_q.push_back(cyc);
        if (fill_reqs_flush) n_fill++;
        if (fill_reqs_flush != (wb_valid && wb_ready)) n_bad++;
        if (inval_en && wb_valid && !wb_ready) n_bad++;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: lines are visited in set-major order; every valid line is
    // invalidated, and valid+dirty lines are written back first.
    task automatic compare_walk(input string nm, input logic [7:0] v, input logic [7:0] d,
                                input int b_inv, input int b_wb);
        int e_inv[$], e_wb[$];
        for (int l = 0; l < LINES; l++) begin
            if (v[l]) e_inv.push_back(l);
            if (v[l] && d[l]) e_wb.push_back(l);
        end
        chk({nm, "_inv_n"}, inv_q.size() - b_inv, e_inv.size());
        chk({nm, "_wb_n"}, wb_q.size() - b_wb, e_wb.size());
        for (int i = 0; i < e_inv.size() && b_inv + i < inv_q.size(); i++)
            chk({nm, "_inv_line"}, inv_q[b_inv + i], e_inv[i]);
        for (int i = 0; i < e_wb.size() && b_wb + i < wb_q.size(); i++)
            chk({nm, "_wb_line"}, wb_q[b_wb + i], e_wb[i]);
    endtask

    bit rnd = 1'b0;

    // Latency counts cycles inclusively: the cycle carrying flush_start is
    // cycle 1, the cycle carrying flush_done is the last one.
    task automatic do_flush(input int repulse, output int lat, output bit ok);
        int b_done = done_q.size();
        int st;
        @(posedge clk); #1;
        flush_start = 1'b1;
        st = cyc;
        @(posedge clk); #1;
        flush_start = 1'b0;
        ok = 1'b0;
        lat = -1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            flush_start = (repulse != 0) && (i == repulse);
            if (rnd) begin
                wb_ready = 1'($urandom_range(0, 1));
                reqs_cnt = 3'($urandom_range(0, 3));
            end
            if (done_q.size() > b_done) begin
                ok = 1'b1;
                break;
            end
        end
        flush_start = 1'b0;
        if (ok) lat = done_q[b_done] - st + 1;
        else chk("done_timeout", 0, 1);
        wb_ready = 1'b1;
        reqs_cnt = 3'd2;
    endtask

    typedef struct {
        logic [7:0] v;
        logic [7:0] d;
        int         n_inv;
        int         n_wb;
        int         lat;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   lat, b_rd, b_inv, b_wb, b_fill, b_done, nd;
        bit   ok, seen;

        // line index = set*2 + way; dirty without valid must be ignored
        vecs[0] = '{8'h00, 8'h00, 0, 0, 26};
        vecs[1] = '{8'h08, 8'h08, 1, 1, 27};
        vecs[2] = '{8'hFF, 8'h00, 8, 0, 26};
        vecs[3] = '{8'hFF, 8'hFF, 8, 8, 34};
        vecs[4] = '{8'h0F, 8'h05, 4, 2, 28};
        vecs[5] = '{8'hA0, 8'hF0, 2, 2, 28};

        repeat (3) @(posedge clk);
        #1 chk("reset_outs", int'(outs()), 0);
        rst = 1'b1;
        @(posedge clk); #1 chk("idle_outs", int'(outs()), 0);

        foreach (vecs[k]) begin
            tv = vecs[k].v; td = vecs[k].d;
            b_rd = rd_q.size(); b_inv = inv_q.size(); b_wb = wb_q.size(); b_fill = n_fill;
            do_flush(0, lat, ok);
            chk("vec_latency", lat, vecs[k].lat);
            chk("vec_rd_n", rd_q.size() - b_rd, LINES);
            chk("vec_inv_n", inv_q.size() - b_inv, vecs[k].n_inv);
            chk("vec_wb_n", wb_q.size() - b_wb, vecs[k].n_wb);
            chk("vec_fill_n", n_fill - b_fill, vecs[k].n_wb);
            chk("vec_busy_after", int'(flush_busy), 0);
            chk("vec_ongoing_after", int'(ongoing), 0);
            chk("vec_ptrs_after", int'({fset, fway}), 0);
`ifdef L2_FLUSH_WB_CNT_EN
            chk("vec_wb_count", int'(wb_count), vecs[k].n_wb);
`endif
            compare_walk("vec", vecs[k].v, vecs[k].d, b_inv, b_wb);
            for (int i = 0; i < LINES && b_rd + i < rd_q.size(); i++)
                chk("vec_rd_order", rd_q[b_rd + i], i);
        end

        // reqs_cnt held at 0: no offer for 5 cycles, then one transfer
        tv = 8'h08; td = 8'h08; reqs_cnt = 3'd0; wb_ready = 1'b1;
        b_fill = n_fill; b_wb = wb_q.size(); b_rd = rd_q.size();
        @(posedge clk); #1 flush_start = 1'b1;
        @(posedge clk); #1 flush_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            seen = (rd_q.size() > b_rd) && (rd_q[$] == 3);
        end
        chk("nocred_reach_line", int'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("nocred_wb_low", int'(wb_valid), 0);
        end
        chk("nocred_fill_none", n_fill - b_fill, 0);
        @(posedge clk); #1 reqs_cnt = 3'd1;
        #1;
        chk("nocred_wb_high", int'(wb_valid), 1);
        chk("nocred_fill", int'(fill_reqs_flush), 1);
        chk("nocred_inval", int'(inval_en), 1);
        b_done = done_q.size();
        for (int i = 0; i < 100 && done_q.size() == b_done; i++) @(posedge clk);
        #1;
        chk("nocred_done", done_q.size() - b_done, 1);
        chk("nocred_wb_n", wb_q.size() - b_wb, 1);
        reqs_cnt = 3'd2;

        // offered writeback stays valid after reqs_cnt falls to 0
        tv = 8'h01; td = 8'h01; reqs_cnt = 3'd1; wb_ready = 1'b0;
        b_wb = wb_q.size();
        @(posedge clk); #1 flush_start = 1'b1;
        @(posedge clk); #1 flush_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            seen = wb_valid;
        end
        chk("sticky_offer", int'(seen), 1);
        @(posedge clk); #1 reqs_cnt = 3'd0;
        #1 chk("sticky_hold1", int'(wb_valid), 1);
        @(posedge clk); #2 chk("sticky_hold2", int'(wb_valid), 1);
        wb_ready = 1'b1;
        #1 chk("sticky_fill", int'(fill_reqs_flush), 1);
        b_done = done_q.size();
        for (int i = 0; i < 100 && done_q.size() == b_done; i++) @(posedge clk);
        #1 chk("sticky_wb_n", wb_q.size() - b_wb, 1);
        reqs_cnt = 3'd2;

        // restart pulse mid-walk is ignored
        tv = 8'hFF; td = 8'h00;
        b_inv = inv_q.size(); b_wb = wb_q.size(); b_done = done_q.size();
        do_flush(10, lat, ok);
        repeat (10) @(posedge clk);
        #1;
        chk("repulse_latency", lat, 26);
        chk("repulse_done_n", done_q.size() - b_done, 1);
        compare_walk("repulse", 8'hFF, 8'h00, b_inv, b_wb);

        // reset while a writeback is pending
        tv = 8'h04; td = 8'h04; reqs_cnt = 3'd1; wb_ready = 1'b0;
        b_done = done_q.size();
        @(posedge clk); #1 flush_start = 1'b1;
        @(posedge clk); #1 flush_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            seen = wb_valid;
        end
        chk("rst_reach_wb", int'(seen), 1);
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        #1 chk("rst_outs", int'(outs()), 0);
        repeat (5) @(posedge clk);
        #1 chk("rst_idle_outs", int'(outs()), 0);
        chk("rst_no_done", done_q.size() - b_done, 0);
        wb_ready = 1'b1;
        b_rd = rd_q.size(); b_inv = inv_q.size(); b_wb = wb_q.size();
        do_flush(0, lat, ok);
        chk("rst_restart_line", (rd_q.size() > b_rd) ? rd_q[b_rd] : -1, 0);
        chk("rst_restart_lat", lat, 27);
        compare_walk("rst_restart", 8'h04, 8'h04, b_inv, b_wb);

        // random contents, always-ready path: exact latency from the model
        for (int t = 0; t < 6; t++) begin
            tv = 8'($urandom); td = 8'($urandom);
            reqs_cnt = 3'($urandom_range(1, 3)); wb_ready = 1'b1;
            nd = 0;
            for (int l = 0; l < LINES; l++) if (tv[l] && td[l]) nd++;
            b_inv = inv_q.size(); b_wb = wb_q.size(); b_fill = n_fill;
            rnd = 1'b0;
            @(posedge clk); #1;
            do_flush(0, lat, ok);
            chk("rand_latency", lat, 3 * LINES + 2 + nd);
            chk("rand_fill_n", n_fill - b_fill, nd);
`ifdef L2_FLUSH_WB_CNT_EN
            chk("rand_wb_count", int'(wb_count), nd);
`endif
            compare_walk("rand", tv, td, b_inv, b_wb);
        end

        // random contents with random handshake / credit pressure
        for (int t = 0; t < 4; t++) begin
            tv = 8'($urandom); td = 8'($urandom);
            nd = 0;
            for (int l = 0; l < LINES; l++) if (tv[l] && td[l]) nd++;
            b_inv = inv_q.size(); b_wb = wb_q.size(); b_fill = n_fill;
            rnd = 1'b1;
            do_flush(0, lat, ok);
            rnd = 1'b0;
            chk("rhs_fill_n", n_fill - b_fill, nd);
            compare_walk("rhs", tv, td, b_inv, b_wb);
        end

        chk("handshake_side_effects", n_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
